opsum_wb_agen: RTL and testbench



---
 rtl/opsum_agen_pkg.sv | 36 +++
 rtl/opsum_cfg_calc.sv | 59 +++++
 rtl/opsum_wb_agen.sv | 137 +++++++++++++
 tb/tb_opsum_wb_agen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/opsum_agen_pkg.sv
// opsum_agen_pkg: shared types and reference base-address helper for the opsum writeback address generator
//   state_t        sequencer states
//   mapping_cfg_t  latched mapping/geometry configuration, fields zero-extended to CFG_MAX bits
//   opsum_base()   reference base byte address in CALC_W bits; callers truncate to their address width
package opsum_agen_pkg;

    localparam int CFG_MAX = 16;
    localparam int CALC_W  = 32;

    typedef enum logic [2:0] {IDLE, CALC1, CALC2, RUN, FIN} state_t;

    typedef struct packed {
        logic [CFG_MAX-1:0] p;
        logic [CFG_MAX-1:0] t;
        logic [CFG_MAX-1:0] q;
        logic [CFG_MAX-1:0] r;
        logic [CFG_MAX-1:0] e;
        logic [CFG_MAX-1:0] stride;
        logic [CFG_MAX-1:0] filt_row;
        logic [CFG_MAX-1:0] filt_col;
        logic [CFG_MAX-1:0] ifmap_col;
        logic [CFG_MAX-1:0] ofmap_col;
        logic [CFG_MAX-1:0] num_pass;
    } mapping_cfg_t;

    function automatic logic [CALC_W-1:0] opsum_base(input mapping_cfg_t c, input int unsigned word_bytes);
        logic [CALC_W-1:0] qr, pt, span;
        qr   = CALC_W'(c.q) * CALC_W'(c.r);
        pt   = CALC_W'(c.p) * CALC_W'(c.t);
        span = CALC_W'(c.stride) * CALC_W'((c.e == '0) ? '0 : c.e - CFG_MAX'(1)) + CALC_W'(c.filt_col);
        return qr * span * CALC_W'(c.ifmap_col)
             + pt * qr * CALC_W'(c.filt_row) * CALC_W'(c.filt_col)
             + pt * CALC_W'(word_bytes);
    endfunction

endpackage

// File: rtl/opsum_cfg_calc.sv
// opsum_cfg_calc: two-stage registered arithmetic producing the opsum base address and element count
//   clk, rst      clock, async active-high reset
//   cfg_i         latched mapping configuration (held stable by the sequencer)
//   base_o        base byte address, valid two cycles after cfg_i settles
//   count_o       elements per pass, same latency as base_o
//   no_work_o     combinational: the count about to be registered is zero, or there are no passes
module opsum_cfg_calc
    import opsum_agen_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 20,
    parameter int WORD_BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  mapping_cfg_t       cfg_i,
    output logic [ADDR_W-1:0]  base_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               no_work_o
);

    logic [CALC_W-1:0]  qr_q, qr_d, pt_q, pt_d, span_q, span_d;
    logic [CFG_MAX-1:0] e_m1;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Products wrap at CALC_W bits; only the low ADDR_W/CNT_W bits are ever kept.
    always_comb begin
        e_m1    = (cfg_i.e == '0) ? '0 : cfg_i.e - CFG_MAX'(1);
        qr_d    = CALC_W'(cfg_i.q) * CALC_W'(cfg_i.r);
        pt_d    = CALC_W'(cfg_i.p) * CALC_W'(cfg_i.t);
        span_d  = CALC_W'(cfg_i.stride) * CALC_W'(e_m1) + CALC_W'(cfg_i.filt_col);
        base_d  = ADDR_W'(qr_q * span_q * CALC_W'(cfg_i.ifmap_col)
                        + pt_q * qr_q * CALC_W'(cfg_i.filt_row) * CALC_W'(cfg_i.filt_col)
                        + pt_q * CALC_W'(WORD_BYTES));
        count_d = CNT_W'(pt_q * CALC_W'(cfg_i.e) * CALC_W'(cfg_i.ofmap_col));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qr_q    <= '0;
            pt_q    <= '0;
            span_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
        end else begin
            qr_q    <= qr_d;
            pt_q    <= pt_d;
            span_q  <= span_d;
            base_q  <= base_d;
            count_q <= count_d;
        end
    end

    assign base_o    = base_q;
    assign count_o   = count_q;
    assign no_work_o = (count_d == '0) || (cfg_i.num_pass == '0);

endmodule

// File: rtl/opsum_wb_agen.sv
// opsum_wb_agen: opsum writeback address generator streaming one GLB word address per output element
//   clk, rst                 clock, async active-high reset
//   start, abort             launch pulse (IDLE only), synchronous return to IDLE
//   cfg_*                    mapping/geometry parameters, pass count and pass byte stride, latched on start
//   addr, addr_valid,        address stream with valid/ready handshake; addr_last marks the
//   addr_ready, addr_last    final element of each pass
//   pass_idx                 current pass index
//   busy, done               non-IDLE indicator, one-cycle completion pulse
module opsum_wb_agen
    import opsum_agen_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CFG_W      = 8,
    parameter int CNT_W      = 20,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CFG_W-1:0]  cfg_p,
    input  logic [CFG_W-1:0]  cfg_t,
    input  logic [CFG_W-1:0]  cfg_q,
    input  logic [CFG_W-1:0]  cfg_r,
    input  logic [CFG_W-1:0]  cfg_e,
    input  logic [CFG_W-1:0]  cfg_stride,
    input  logic [CFG_W-1:0]  cfg_filt_row,
    input  logic [CFG_W-1:0]  cfg_filt_col,
    input  logic [CFG_W-1:0]  cfg_ifmap_col,
    input  logic [CFG_W-1:0]  cfg_ofmap_col,
    input  logic [CFG_W-1:0]  cfg_num_pass,
    input  logic [ADDR_W-1:0] cfg_pass_stride,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_last,
    output logic [CNT_W-1:0]  pass_idx,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    mapping_cfg_t      mcfg_q, mcfg_d;
    logic [ADDR_W-1:0] pstride_q, pstride_d, pass_off_q, pass_off_d, elem_off_q, elem_off_d, base;
    logic [CNT_W-1:0]  i_q, i_d, k_q, k_d, count;
    logic              no_work, xfer, last_pass;

    opsum_cfg_calc #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .WORD_BYTES(WORD_BYTES)) u_calc (
        .clk       (clk),
        .rst       (rst),
        .cfg_i     (mcfg_q),
        .base_o    (base),
        .count_o   (count),
        .no_work_o (no_work)
    );

    assign addr_valid = state_q == RUN;
    assign addr_last  = addr_valid && (i_q == count - CNT_W'(1));
    assign xfer       = addr_valid && addr_ready;
    assign last_pass  = k_q == CNT_W'(mcfg_q.num_pass) - CNT_W'(1);
    // Two running offsets replace the k*pass_stride and i*WORD_BYTES products.
    assign addr       = base + pass_off_q + elem_off_q;
    assign pass_idx   = k_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == FIN;

    always_comb begin
        state_d    = state_q;
        mcfg_d     = mcfg_q;
        pstride_d  = pstride_q;
        i_d        = i_q;
        k_d        = k_q;
        pass_off_d = pass_off_q;
        elem_off_d = elem_off_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = CALC1;
                mcfg_d    = '{p: CFG_MAX'(cfg_p), t: CFG_MAX'(cfg_t), q: CFG_MAX'(cfg_q), r: CFG_MAX'(cfg_r),
                              e: CFG_MAX'(cfg_e), stride: CFG_MAX'(cfg_stride),
                              filt_row: CFG_MAX'(cfg_filt_row), filt_col: CFG_MAX'(cfg_filt_col),
                              ifmap_col: CFG_MAX'(cfg_ifmap_col), ofmap_col: CFG_MAX'(cfg_ofmap_col),
                              num_pass: CFG_MAX'(cfg_num_pass)};
                pstride_d = cfg_pass_stride;
            end
            CALC1: state_d = CALC2;
            CALC2: state_d = no_work ? FIN : RUN;
            RUN: if (xfer) begin
                if (addr_last) begin
                    i_d        = '0;
                    elem_off_d = '0;
                    if (last_pass) state_d = FIN;
                    else begin
                        k_d        = k_q + CNT_W'(1);
                        pass_off_d = pass_off_q + pstride_q;
                    end
                end else begin
                    i_d        = i_q + CNT_W'(1);
                    elem_off_d = elem_off_q + ADDR_W'(WORD_BYTES);
                end
            end
            FIN: begin
                state_d    = IDLE;
                k_d        = '0;
                pass_off_d = '0;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            i_d        = '0;
            k_d        = '0;
            pass_off_d = '0;
            elem_off_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mcfg_q     <= '0;
            pstride_q  <= '0;
            i_q        <= '0;
            k_q        <= '0;
            pass_off_q <= '0;
            elem_off_q <= '0;
        end else begin
            state_q    <= state_d;
            mcfg_q     <= mcfg_d;
            pstride_q  <= pstride_d;
            i_q        <= i_d;
            k_q        <= k_d;
            pass_off_q <= pass_off_d;
            elem_off_q <= elem_off_d;
        end
    end

endmodule

// File: tb/tb_opsum_wb_agen.sv
// tb_opsum_wb_agen: directed table-driven bench for opsum_wb_agen (16-bit and 8-bit address instances)
module tb_opsum_wb_agen;
    import opsum_agen_pkg::*;

    logic        clk = 0, rst = 1, start = 0, abort = 0, addr_ready = 0;
    logic [7:0]  cfg_p, cfg_t, cfg_q, cfg_r, cfg_e, cfg_stride, cfg_filt_row, cfg_filt_col;
    logic [7:0]  cfg_ifmap_col, cfg_ofmap_col, cfg_num_pass;
    logic [15:0] cfg_pass_stride;
    logic [15:0] addr16;
    logic [7:0]  addr8;
    logic [19:0] pi16, pi8;
    logic        v16, v8, l16, l8, busy16, busy8, done16, done8;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    opsum_wb_agen u16 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_p(cfg_p), .cfg_t(cfg_t), .cfg_q(cfg_q), .cfg_r(cfg_r), .cfg_e(cfg_e),
        .cfg_stride(cfg_stride), .cfg_filt_row(cfg_filt_row), .cfg_filt_col(cfg_filt_col),
        .cfg_ifmap_col(cfg_ifmap_col), .cfg_ofmap_col(cfg_ofmap_col), .cfg_num_pass(cfg_num_pass),
        .cfg_pass_stride(cfg_pass_stride),
        .addr(addr16), .addr_valid(v16), .addr_ready(addr_ready), .addr_last(l16),
        .pass_idx(pi16), .busy(busy16), .done(done16)
    );

    opsum_wb_agen #(.ADDR_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_p(cfg_p), .cfg_t(cfg_t), .cfg_q(cfg_q), .cfg_r(cfg_r), .cfg_e(cfg_e),
        .cfg_stride(cfg_stride), .cfg_filt_row(cfg_filt_row), .cfg_filt_col(cfg_filt_col),
        .cfg_ifmap_col(cfg_ifmap_col), .cfg_ofmap_col(cfg_ofmap_col), .cfg_num_pass(cfg_num_pass),
        .cfg_pass_stride(cfg_pass_stride[7:0]),
        .addr(addr8), .addr_valid(v8), .addr_ready(addr_ready), .addr_last(l8),
        .pass_idx(pi8), .busy(busy8), .done(done8)
    );

    typedef struct {
        int p, t, q, r, e, s, fr, fc, ic, oc, np, ps;
        int base, cnt, abort_at;
        bit bp, w8, bs;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_p = 8'(v.p); cfg_t = 8'(v.t); cfg_q = 8'(v.q); cfg_r = 8'(v.r); cfg_e = 8'(v.e);
        cfg_stride = 8'(v.s); cfg_filt_row = 8'(v.fr); cfg_filt_col = 8'(v.fc);
        cfg_ifmap_col = 8'(v.ic); cfg_ofmap_col = 8'(v.oc); cfg_num_pass = 8'(v.np);
        cfg_pass_stride = 16'(v.ps);
    endtask

    task automatic run(input vec_t v);
        int mask, total, first, xf, k, i, dcnt, dcyc, lcyc, acyc, a, pa, pi, ppi;
        bit val, l, pl, held, b, d;
        mapping_cfg_t c;
        mask = v.w8 ? 'hFF : 'hFFFF;
        total = (v.abort_at > 0) ? v.abort_at : v.cnt * v.np;
        first = -1; xf = 0; k = 0; i = 0; dcnt = 0; dcyc = -1; lcyc = -1; acyc = -1;
        held = 0; pa = 0; pl = 0; ppi = 0; b = 1;
        c = '{p: 16'(v.p), t: 16'(v.t), q: 16'(v.q), r: 16'(v.r), e: 16'(v.e), stride: 16'(v.s),
              filt_row: 16'(v.fr), filt_col: 16'(v.fc), ifmap_col: 16'(v.ic), ofmap_col: 16'(v.oc),
              num_pass: 16'(v.np)};
        chk("pkg_base", longint'(opsum_base(c, 4)) & mask, v.base);
        set_cfg(v);
        @(negedge clk);
        start = 1;
        addr_ready = 1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = v.bs && cyc == 4;
            abort = 0;
            if (cyc == 1) begin
                cfg_ifmap_col = 8'd1; cfg_ofmap_col = 8'd9; cfg_num_pass = 8'd5;
                cfg_p = 8'd7; cfg_pass_stride = 16'h1234;
            end
            a = v.w8 ? int'(addr8) : int'(addr16);
            val = v.w8 ? v8 : v16;
            l = v.w8 ? l8 : l16;
            pi = v.w8 ? int'(pi8) : int'(pi16);
            b = v.w8 ? busy8 : busy16;
            d = v.w8 ? done8 : done16;
            if (held) begin
                chk("hold_valid", val, 1);
                chk("hold_addr", a, pa);
                chk("hold_last", l, pl);
                chk("hold_pass", pi, ppi);
            end
            if (acyc > 0 && cyc == acyc + 1) chk("abort_drop", val, 0);
            addr_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
            held = 0;
            if (val) begin
                if (first < 0) first = cyc;
                chk("busy_run", b, 1);
                if (addr_ready) begin
                    chk("addr", a, (v.base + k * v.ps + i * 4) & mask);
                    chk("last", l, i == v.cnt - 1);
                    chk("pass_idx", pi, k);
                    xf++;
                    lcyc = cyc;
                    if (i == v.cnt - 1) begin i = 0; k++; end else i++;
                    if (xf == v.abort_at) begin abort = 1; acyc = cyc; end
                end else begin
                    held = 1; pa = a; pl = l; ppi = pi;
                end
            end
            if (d) begin dcnt++; dcyc = cyc; end
            if ((dcyc > 0 && cyc >= dcyc + 3) || (acyc > 0 && cyc >= acyc + 3)) break;
        end
        abort = 0;
        start = 0;
        chk("xfers", xf, total);
        chk("first_valid", first, total > 0 ? 3 : -1);
        chk("done_count", dcnt, v.abort_at > 0 ? 0 : 1);
        if (v.abort_at == 0) chk("done_cycle", dcyc, total > 0 ? lcyc + 1 : 3);
        chk("busy_after", b, 0);
    endtask

    initial begin
        //           p t q r e s fr fc ic oc np  ps   base cnt ab bp w8 bs
        vecs[0] = '{1,1,1,1,2,1, 3, 3, 4, 2, 1,   0,  29, 4, 0, 0, 0, 0};
        vecs[1] = '{1,1,1,1,2,1, 3, 3, 4, 2, 2, 256,  29, 4, 0, 0, 0, 0};
        vecs[2] = '{1,1,1,1,2,1, 3, 3, 4, 2, 1,   0,  29, 4, 0, 1, 0, 0};
        vecs[3] = '{1,1,1,1,2,1, 3, 3, 4, 0, 1,   0,  29, 0, 0, 0, 0, 0};
        vecs[4] = '{1,1,1,1,2,1, 3, 3, 4, 2, 0,   0,  29, 4, 0, 0, 0, 0};
        vecs[5] = '{1,1,1,1,2,1, 3, 3, 4, 2, 1,   0,  29, 4, 2, 0, 0, 0};
        vecs[6] = '{1,1,1,1,2,1, 3, 3, 4, 2, 1,   0,  29, 4, 0, 0, 0, 0};
        vecs[7] = '{1,1,1,1,2,1, 3, 3,60, 2, 1,   0, 253, 4, 0, 0, 1, 1};
        vecs[8] = '{2,1,2,1,3,2, 2, 3,10, 1, 3,  64, 172, 6, 0, 0, 0, 0};
        set_cfg(vecs[0]);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_addr", addr16, 0);
        chk("rst_valid", v16, 0);
        chk("rst_last", l16, 0);
        chk("rst_pass_idx", pi16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        for (int n = 0; n < 9; n++) run(vecs[n]);
        set_cfg(vecs[0]);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int j = 0; j < 10 && !v16; j++) @(negedge clk);
        chk("mid_run_valid", v16, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", v16, 0);
        chk("async_rst_busy", busy16, 0);
        chk("async_rst_valid8", v8, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_busy", busy16, 0);
        chk("post_rst_done", done16, 0);
        run(vecs[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
